// File: rtl/shifter_framer.sv
// shifter_framer: bit-serial deserialiser with masked sync hunt, periodic sync re-check and flywheel loss-of-lock.
module shifter_framer #(
    parameter int WIDTH       = 32,
    parameter int SYMB        = 4,
    parameter bit MSB_FIRST   = 1,
    parameter int FRAME_WORDS = 8,
    parameter int MAX_ERR     = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         data_i,
    input  logic                         data_val_i,
    input  logic                         hunt_i,
    input  logic [WIDTH-1:0]             pattern_i,
    input  logic [WIDTH-1:0]             mask_i,
    output logic [WIDTH-1:0]             word_o,
    output logic                         word_val_o,
    output logic [SYMB-1:0]              sym_o,
    output logic                         sym_val_o,
    output logic                         sync_o,
    output logic                         lost_o,
    output logic                         locked_o,
    output logic [$clog2(MAX_ERR+1)-1:0] err_cnt_o
);
    localparam int BCW = $clog2(WIDTH);
    localparam int WCW = FRAME_WORDS > 1 ? $clog2(FRAME_WORDS) : 1;
    localparam int ECW = $clog2(MAX_ERR + 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
    localparam logic [WCW-1:0] WORD_LAST = WCW'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {HUNT, DATA, CHECK} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sr, sr_nxt;
    logic [SYMB-1:0]  sym_nxt;
    logic [BCW-1:0]   bit_cnt, bit_nxt;
    logic [WCW-1:0]   word_cnt, wc_nxt;
    logic [ECW-1:0]   err_cnt, err_nxt;
    logic             match, last_bit, sym_end;
    logic             word_stb, sym_stb, sync_stb, lost_stb;

    assign sr_nxt    = MSB_FIRST ? {sr[WIDTH-2:0], data_i} : {data_i, sr[WIDTH-1:1]};
    assign sym_nxt   = MSB_FIRST ? sr_nxt[SYMB-1:0] : sr_nxt[WIDTH-1:WIDTH-SYMB];
    assign match     = ~|((sr_nxt ^ pattern_i) & mask_i) && |mask_i;
    assign last_bit  = bit_cnt == BIT_LAST;
    assign sym_end   = (32'(bit_cnt) % SYMB) == SYMB - 1;
    assign locked_o  = state != HUNT;
    assign err_cnt_o = err_cnt;

    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        wc_nxt    = word_cnt;
        err_nxt   = err_cnt;
        word_stb  = 1'b0;
        sym_stb   = 1'b0;
        sync_stb  = 1'b0;
        lost_stb  = 1'b0;
        if (hunt_i) begin
            state_nxt = HUNT;
            bit_nxt   = '0;
            wc_nxt    = '0;
            err_nxt   = '0;
        end else if (data_val_i) begin
            case (state)
                HUNT: if (match) begin
                    sync_stb  = 1'b1;
                    bit_nxt   = '0;
                    wc_nxt    = '0;
                    err_nxt   = '0;
                    state_nxt = DATA;
                end
                DATA: begin
                    bit_nxt  = last_bit ? '0 : bit_cnt + 1'b1;
                    sym_stb  = sym_end;
                    word_stb = last_bit;
                    if (last_bit) begin
                        if (FRAME_WORDS != 0 && word_cnt == WORD_LAST) begin
                            wc_nxt    = '0;
                            state_nxt = CHECK;
                        end else begin
                            wc_nxt = word_cnt + 1'b1;
                        end
                    end
                end
                CHECK: begin
                    bit_nxt = last_bit ? '0 : bit_cnt + 1'b1;
                    if (last_bit) begin
                        if (match) begin
                            sync_stb  = 1'b1;
                            err_nxt   = '0;
                            state_nxt = DATA;
                        end else if (32'(err_cnt) + 1 < MAX_ERR) begin
                            err_nxt   = err_cnt + 1'b1;
                            state_nxt = DATA;
                        end else begin
                            lost_stb  = 1'b1;
                            err_nxt   = '0;
                            state_nxt = HUNT;
                        end
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            sr         <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            err_cnt    <= '0;
            word_o     <= '0;
            sym_o      <= '0;
            word_val_o <= 1'b0;
            sym_val_o  <= 1'b0;
            sync_o     <= 1'b0;
            lost_o     <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_nxt;
            word_cnt   <= wc_nxt;
            err_cnt    <= err_nxt;
            word_val_o <= word_stb;
            sym_val_o  <= sym_stb;
            sync_o     <= sync_stb;
            lost_o     <= lost_stb;
            if (data_val_i) sr <= sr_nxt;
            if (word_stb) word_o <= sr_nxt;
            if (sym_stb) sym_o <= sym_nxt;
        end
    end
endmodule

// File: tb/tb_shifter_framer.sv
// tb_shifter_framer: MSB-first and LSB-first framers driven with the same words, checked against a word-slot reference model.
module tb_shifter_framer;
    localparam int W  = 32;
    localparam int FW = 2;
    localparam int ME = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          data_val = 1'b0;
    logic          hunt = 1'b0;
    logic [1:0]    data = 2'b00;
    logic [W-1:0]  pattern = 32'hA5A5F00F;
    logic [W-1:0]  mask = 32'hFFFFFFFF;
    logic [W-1:0]  word_o [2];
    logic [3:0]    sym_o [2];
    logic [1:0]    err_o [2];
    logic [1:0]    word_val, sym_val, sync_o, lost_o, locked_o;

    logic [W-1:0]  win [2], e_word [2];
    logic [3:0]    e_sym [2];
    bit            e_wv [2], e_sv [2], e_sync [2], e_lost [2], lk [2];
    int            pos [2], miss [2];
    int            n_cmp = 0, n_bad = 0, wv_seen = 0;
    bit            gaps = 1'b0;

    always #5 clk = ~clk;

    shifter_framer #(.WIDTH(W), .SYMB(4), .MSB_FIRST(1), .FRAME_WORDS(FW), .MAX_ERR(ME)) dut_m (
        .clk(clk), .rst_n(rst_n), .data_i(data[0]), .data_val_i(data_val), .hunt_i(hunt),
        .pattern_i(pattern), .mask_i(mask), .word_o(word_o[0]), .word_val_o(word_val[0]),
        .sym_o(sym_o[0]), .sym_val_o(sym_val[0]), .sync_o(sync_o[0]), .lost_o(lost_o[0]),
        .locked_o(locked_o[0]), .err_cnt_o(err_o[0]));

    shifter_framer #(.WIDTH(W), .SYMB(4), .MSB_FIRST(0), .FRAME_WORDS(FW), .MAX_ERR(ME)) dut_l (
        .clk(clk), .rst_n(rst_n), .data_i(data[1]), .data_val_i(data_val), .hunt_i(hunt),
        .pattern_i(pattern), .mask_i(mask), .word_o(word_o[1]), .word_val_o(word_val[1]),
        .sym_o(sym_o[1]), .sym_val_o(sym_val[1]), .sync_o(sync_o[1]), .lost_o(lost_o[1]),
        .locked_o(locked_o[1]), .err_cnt_o(err_o[1]));

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit hit(logic [W-1:0] w);
        return mask != 0 && ((w ^ pattern) & mask) == 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            win[i] = '0; e_word[i] = '0; e_sym[i] = '0;
            e_wv[i] = 0; e_sv[i] = 0; e_sync[i] = 0; e_lost[i] = 0;
            lk[i] = 0; pos[i] = 0; miss[i] = 0;
        end
    endtask

    // pos counts bits since alignment; every frame is FW data word slots followed by one sync slot
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int k, slot;
            e_wv[i] = 0; e_sv[i] = 0; e_sync[i] = 0; e_lost[i] = 0;
            if (data_val)
                win[i] = i == 0 ? (win[i] << 1) | W'(data[0]) : (win[i] >> 1) | (W'(data[1]) << (W - 1));
            if (hunt) begin
                lk[i] = 0; pos[i] = 0; miss[i] = 0;
            end else if (data_val) begin
                if (!lk[i]) begin
                    if (hit(win[i])) begin
                        e_sync[i] = 1; lk[i] = 1; pos[i] = 0; miss[i] = 0;
                    end
                end else begin
                    k = pos[i] % W;
                    slot = (pos[i] / W) % (FW + 1);
                    pos[i]++;
                    if (slot < FW) begin
                        if (k % 4 == 3) begin
                            e_sv[i] = 1;
                            e_sym[i] = i == 0 ? win[i][3:0] : win[i][W-1:W-4];
                        end
                        if (k == W - 1) begin
                            e_wv[i] = 1;
                            e_word[i] = win[i];
                        end
                    end else if (k == W - 1) begin
                        if (hit(win[i])) begin
                            e_sync[i] = 1; miss[i] = 0;
                        end else if (miss[i] + 1 < ME) begin
                            miss[i]++;
                        end else begin
                            e_lost[i] = 1; miss[i] = 0; lk[i] = 0; pos[i] = 0;
                        end
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("d%0d word_o", i), word_o[i], e_word[i]);
            chk($sformatf("d%0d word_val", i), word_val[i], e_wv[i]);
            chk($sformatf("d%0d sym_o", i), sym_o[i], e_sym[i]);
            chk($sformatf("d%0d sym_val", i), sym_val[i], e_sv[i]);
            chk($sformatf("d%0d sync_o", i), sync_o[i], e_sync[i]);
            chk($sformatf("d%0d lost_o", i), lost_o[i], e_lost[i]);
            chk($sformatf("d%0d locked_o", i), locked_o[i], lk[i]);
            chk($sformatf("d%0d err_cnt", i), err_o[i], miss[i]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
        compare_all();
        if (word_val[0]) wv_seen++;
    endtask

    task automatic send_bit(logic bm, logic bl);
        while (gaps && $urandom_range(1) == 1) begin
            data_val = 1'b0;
            data = 2'($urandom);
            cycle();
        end
        data_val = 1'b1;
        data = {bl, bm};
        cycle();
        data_val = 1'b0;
    endtask

    task automatic send_bits(logic [W-1:0] w, int a, int b);
        for (int i = a; i < b; i++) send_bit(w[W-1-i], w[i]);
    endtask

    task automatic send_word(logic [W-1:0] w);
        send_bits(w, 0, W);
    endtask

    function automatic logic [W-1:0] bad_word();
        logic [W-1:0] w = $urandom;
        return w == pattern ? w ^ 32'h1 : w;
    endfunction

    initial begin
        logic [W-1:0] pre;
        model_reset();
        repeat (3) cycle();
        chk("reset locked", locked_o, 2'b00);
        chk("reset word", word_o[0], 32'h0);
        rst_n = 1'b1;
        cycle();
        // alignment: 5 random bits then the sync word, then 12345678
        pre = $urandom;
        send_bits(pre, W - 5, W);
        send_word(pattern);
        chk("first sync", sync_o, 2'b11);
        send_bits(32'h12345678, 0, 4);
        chk("msb first sym", sym_o[0], 4'h1);
        chk("lsb first sym", sym_o[1], 4'h8);
        send_bits(32'h12345678, 4, W);
        chk("msb word", word_o[0], 32'h12345678);
        chk("lsb word", word_o[1], 32'h12345678);
        chk("word+sym strobe", {word_val[0], sym_val[0], sym_o[0]}, {2'b11, 4'h8});
        send_word($urandom);
        send_word(pattern);
        // flywheel: one corrupted sync slot is tolerated
        wv_seen = 0;
        send_word($urandom); send_word($urandom);
        send_word(bad_word());
        chk("fly err1", err_o[0], 2'd1);
        chk("fly locked", locked_o[0], 1'b1);
        send_word($urandom); send_word($urandom);
        send_word(pattern);
        chk("fly err0", err_o[0], 2'd0);
        chk("fly words", wv_seen, 4);
        // three consecutive misses lose lock
        for (int n = 0; n < ME; n++) begin
            send_word($urandom); send_word($urandom);
            send_word(bad_word());
        end
        chk("lost strobe", lost_o[0], 1'b1);
        chk("lost locked", locked_o[0], 1'b0);
        wv_seen = 0;
        send_word($urandom); send_word($urandom);
        chk("no words after loss", wv_seen, 0);
        // masked pattern with stalls
        hunt = 1'b1; cycle(); hunt = 1'b0;
        mask = 32'hFFFF0000;
        pattern = 32'hA5A50000;
        gaps = 1'b1;
        send_word(32'h0);
        send_word(32'hA5A5BEEF);
        chk("mask sync", sync_o[0], 1'b1);
        for (int n = 0; n < 4; n++) send_word($urandom);
        // hunt request mid-word
        pre = $urandom;
        send_bits(pre, 0, 10);
        hunt = 1'b1;
        send_bits(pre, 10, 11);
        hunt = 1'b0;
        wv_seen = 0;
        send_bits(pre, 11, W);
        chk("hunt no word", wv_seen, 0);
        chk("hunt unlocked", locked_o[0], 1'b0);
        send_word(32'h0);
        send_word(32'hA5A5BEEF);
        chk("rematch", sync_o[0], 1'b1);
        // reset in the middle of a sync slot
        send_word($urandom); send_word($urandom);
        send_bits(32'hA5A5BEEF, 0, 10);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("rst outputs", {word_o[0], sym_o[0], word_val[0], sym_val[0], sync_o[0], lost_o[0], locked_o[0], err_o[0]}, 32'h0);
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (3) cycle();
        chk("post rst locked", locked_o, 2'b00);
        send_word(32'h0);
        send_word(32'hA5A5BEEF);
        chk("post rst sync", sync_o[0], 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
